// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for a 5-stage MIPS pipeline.
// Keeps a shadow copy of the destination and timing info for the E, M and W
// stages. From that copy it generates the stall, the D/E flush and the
// operand forwarding selects, and it tracks the mult/div busy window.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   Rs_D, Rt_D              D-stage source register fields
//   Tuse_rs_D, Tuse_rt_D    cycles until each source is needed (3 = unused)
//   RegWrite_D, WriteReg_D  D-stage destination
//   Tnew_D                  cycles after entering E until the result is ready
//   md_start_D, md_div_D    D-stage instruction starts a mult (0) or div (1)
//   md_use_D                D-stage instruction touches HI/LO or the MDU
//   Stall_F, Stall_D, CLR_E hold PC, hold F/D, flush D/E
//   ForwardA_D, ForwardB_D  D operand select: 0 GRF, 1 M result, 2 E result
//   ForwardA_E, ForwardB_E  E operand select: 0 D/E reg, 1 W result, 2 M result
//   ForwardWD_M             M store data taken from the W result
//   md_busy                 MDU busy counter is nonzero
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs_D,
  input  logic [4:0] Rt_D,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic       RegWrite_D,
  input  logic [4:0] WriteReg_D,
  input  logic [1:0] Tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       CLR_E,
  output logic [1:0] ForwardA_D,
  output logic [1:0] ForwardB_D,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       ForwardWD_M,
  output logic       md_busy
);

  // E-stage shadow
  logic       wr_e_q, st_e_q, dv_e_q;
  logic [4:0] a_e_q, rs_e_q, rt_e_q;
  logic [1:0] tn_e_q;
  // M-stage shadow
  logic       wr_m_q;
  logic [4:0] a_m_q, rt_m_q;
  logic [1:0] tn_m_q;
  // W-stage shadow
  logic       wr_w_q;
  logic [4:0] a_w_q;
  // MDU busy counter
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       stall;
  logic       stall_rs, stall_rt, stall_md;
  logic [1:0] tn_m_d;

  // A source needs a stall when a pending writer will not have its result
  // ready by the time the consumer needs it.
  function automatic logic src_stall(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic wr_e, input logic [4:0] a_e,
                                     input logic [1:0] tn_e, input logic wr_m,
                                     input logic [4:0] a_m, input logic [1:0] tn_m);
    logic hit_e, hit_m;
    hit_e = wr_e && (a_e == src) && (tn_e > tuse);
    hit_m = wr_m && (a_m == src) && (tn_m > tuse);
    return (tuse != 2'd3) && (src != 5'd0) && (hit_e || hit_m);
  endfunction

  function automatic logic [1:0] fwd_d(input logic [4:0] src,
                                       input logic wr_e, input logic [4:0] a_e,
                                       input logic [1:0] tn_e, input logic wr_m,
                                       input logic [4:0] a_m, input logic [1:0] tn_m);
    logic [1:0] sel;
    sel = 2'd0;
    if (wr_e && (a_e == src) && (a_e != 5'd0) && (tn_e == 2'd0))
      sel = 2'd2;
    else if (wr_m && (a_m == src) && (a_m != 5'd0) && (tn_m == 2'd0))
      sel = 2'd1;
    return sel;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] src,
                                       input logic wr_m, input logic [4:0] a_m,
                                       input logic [1:0] tn_m, input logic wr_w,
                                       input logic [4:0] a_w);
    logic [1:0] sel;
    sel = 2'd0;
    if (wr_m && (a_m == src) && (a_m != 5'd0) && (tn_m == 2'd0))
      sel = 2'd2;
    else if (wr_w && (a_w == src) && (a_w != 5'd0))
      sel = 2'd1;
    return sel;
  endfunction

  always_comb begin
    stall_rs = src_stall(Rs_D, Tuse_rs_D, wr_e_q, a_e_q, tn_e_q, wr_m_q, a_m_q, tn_m_q);
    stall_rt = src_stall(Rt_D, Tuse_rt_D, wr_e_q, a_e_q, tn_e_q, wr_m_q, a_m_q, tn_m_q);
    // A mult/div sitting in E has not loaded the counter yet, so it counts as busy.
    stall_md = md_use_D && (st_e_q || (cnt_q != '0));
    stall    = stall_rs || stall_rt || stall_md;

    Stall_F = stall;
    Stall_D = stall;
    CLR_E   = stall;

    ForwardA_D  = fwd_d(Rs_D, wr_e_q, a_e_q, tn_e_q, wr_m_q, a_m_q, tn_m_q);
    ForwardB_D  = fwd_d(Rt_D, wr_e_q, a_e_q, tn_e_q, wr_m_q, a_m_q, tn_m_q);
    ForwardA_E  = fwd_e(rs_e_q, wr_m_q, a_m_q, tn_m_q, wr_w_q, a_w_q);
    ForwardB_E  = fwd_e(rt_e_q, wr_m_q, a_m_q, tn_m_q, wr_w_q, a_w_q);
    ForwardWD_M = wr_w_q && (a_w_q == rt_m_q) && (a_w_q != 5'd0);
    md_busy     = (cnt_q != '0);
  end

  always_comb begin
    tn_m_d = (tn_e_q == 2'd0) ? 2'd0 : tn_e_q - 2'd1;
    cnt_d  = cnt_q;
    if (st_e_q)
      cnt_d = dv_e_q ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_e_q <= 1'b0; a_e_q <= '0; tn_e_q <= '0; rs_e_q <= '0;
      rt_e_q <= '0;   st_e_q <= 1'b0; dv_e_q <= 1'b0;
      wr_m_q <= 1'b0; a_m_q <= '0; tn_m_q <= '0; rt_m_q <= '0;
      wr_w_q <= 1'b0; a_w_q <= '0;
      cnt_q  <= '0;
    end else begin
      // A stall flushes D/E, so the E shadow receives a bubble.
      if (stall) begin
        wr_e_q <= 1'b0; a_e_q <= '0; tn_e_q <= '0; rs_e_q <= '0;
        rt_e_q <= '0;   st_e_q <= 1'b0; dv_e_q <= 1'b0;
      end else begin
        wr_e_q <= RegWrite_D;
        a_e_q  <= WriteReg_D;
        tn_e_q <= Tnew_D;
        rs_e_q <= Rs_D;
        rt_e_q <= Rt_D;
        st_e_q <= md_start_D;
        dv_e_q <= md_div_D;
      end
      wr_m_q <= wr_e_q;
      a_m_q  <= a_e_q;
      tn_m_q <= tn_m_d;
      rt_m_q <= rt_e_q;
      wr_w_q <= wr_m_q;
      a_w_q  <= a_m_q;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs_D, Rt_D, WriteReg_D;
  logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_D;
  logic       RegWrite_D, md_start_D, md_div_D, md_use_D;
  logic       Stall_F, Stall_D, CLR_E, ForwardWD_M, md_busy;
  logic [1:0] ForwardA_D, ForwardB_D, ForwardA_E, ForwardB_E;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
    .RegWrite_D(RegWrite_D), .WriteReg_D(WriteReg_D), .Tnew_D(Tnew_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .CLR_E(CLR_E),
    .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ForwardWD_M(ForwardWD_M), .md_busy(md_busy)
  );

  // Reference model: each in-flight instruction remembers the absolute cycle
  // its result becomes ready; MDU busy is an absolute cycle window.
  typedef struct {
    bit wr;
    int dst;
    int rs;
    int rt;
    int ready;
    bit is_md;
    bit is_div;
  } ent_t;

  ent_t pipe[$];  // [0]=E, [1]=M, [2]=W
  int   cyc;
  bit   md_v;
  int   md_t, md_lat;

  int n_cmp = 0;
  int n_bad = 0;

  bit   exp_stall, exp_wd, exp_busy;
  int   exp_fad, exp_fbd, exp_fae, exp_fbe;
  bit   obs_stall, obs_busy, obs_wd;

  function automatic int rem(ent_t e);
    int r;
    r = e.ready - cyc;
    return (r > 0) ? r : 0;
  endfunction

  function automatic ent_t bubble();
    ent_t e;
    e.wr = 0; e.dst = 0; e.rs = 0; e.rt = 0; e.ready = 0; e.is_md = 0; e.is_div = 0;
    return e;
  endfunction

  function automatic bit m_src_stall(int src, int tuse);
    if (tuse == 3 || src == 0) return 0;
    for (int i = 0; i < 2; i++)
      if (pipe[i].wr && pipe[i].dst == src && rem(pipe[i]) > tuse) return 1;
    return 0;
  endfunction

  function automatic int m_fwd_d(int src);
    if (src == 0) return 0;
    if (pipe[0].wr && pipe[0].dst == src && rem(pipe[0]) == 0) return 2;
    if (pipe[1].wr && pipe[1].dst == src && rem(pipe[1]) == 0) return 1;
    return 0;
  endfunction

  function automatic int m_fwd_e(int src);
    if (src == 0) return 0;
    if (pipe[1].wr && pipe[1].dst == src && rem(pipe[1]) == 0) return 2;
    if (pipe[2].wr && pipe[2].dst == src) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_d(input int rs, input int rt, input int tur, input int tut,
                       input bit rw, input int wreg, input int tn,
                       input bit ms, input bit mdv, input bit mu);
    Rs_D = 5'(rs); Rt_D = 5'(rt); Tuse_rs_D = 2'(tur); Tuse_rt_D = 2'(tut);
    RegWrite_D = rw; WriteReg_D = 5'(wreg); Tnew_D = 2'(tn);
    md_start_D = ms; md_div_D = mdv; md_use_D = mu;
  endtask

  task automatic quiet();
    set_d(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle: check outputs at negedge, then advance the model at posedge.
  task automatic cycle();
    bit busy;
    ent_t e;
    @(negedge clk);
    busy      = md_v && (cyc > md_t) && (cyc <= md_t + md_lat);
    exp_stall = m_src_stall(int'(Rs_D), int'(Tuse_rs_D)) ||
                m_src_stall(int'(Rt_D), int'(Tuse_rt_D)) ||
                (md_use_D && (pipe[0].is_md || busy));
    exp_busy  = busy;
    exp_fad   = m_fwd_d(int'(Rs_D));
    exp_fbd   = m_fwd_d(int'(Rt_D));
    exp_fae   = m_fwd_e(pipe[0].rs);
    exp_fbe   = m_fwd_e(pipe[0].rt);
    exp_wd    = pipe[2].wr && pipe[2].dst != 0 && pipe[2].dst == pipe[1].rt;
    obs_stall = Stall_F; obs_busy = md_busy; obs_wd = ForwardWD_M;
    chk("Stall_F", {3'b0, Stall_F}, {3'b0, exp_stall});
    chk("Stall_D", {3'b0, Stall_D}, {3'b0, exp_stall});
    chk("CLR_E", {3'b0, CLR_E}, {3'b0, exp_stall});
    chk("ForwardA_D", {2'b0, ForwardA_D}, 4'(exp_fad));
    chk("ForwardB_D", {2'b0, ForwardB_D}, 4'(exp_fbd));
    chk("ForwardA_E", {2'b0, ForwardA_E}, 4'(exp_fae));
    chk("ForwardB_E", {2'b0, ForwardB_E}, 4'(exp_fbe));
    chk("ForwardWD_M", {3'b0, ForwardWD_M}, {3'b0, exp_wd});
    chk("md_busy", {3'b0, md_busy}, {3'b0, exp_busy});
    @(posedge clk);
    if (reset) begin
      pipe = {bubble(), bubble(), bubble()};
      md_v = 0;
    end else begin
      if (pipe[0].is_md) begin
        md_v = 1; md_t = cyc; md_lat = pipe[0].is_div ? DIV_CYC : MULT_CYC;
      end
      e = bubble();
      if (!exp_stall) begin
        e.wr = RegWrite_D; e.dst = int'(WriteReg_D); e.rs = int'(Rs_D); e.rt = int'(Rt_D);
        e.ready = cyc + 1 + int'(Tnew_D); e.is_md = md_start_D; e.is_div = md_div_D;
      end
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
    cyc++;
    #1;
  endtask

  task automatic md_run(input bit is_div, output int n_stall, output int n_busy);
    set_d(1, 2, 1, 1, 0, 0, 1, 1, is_div, 1);
    cycle();
    set_d(0, 0, 3, 3, 1, 4, 1, 0, 0, 1);  // mfhi $4
    n_stall = 0; n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (obs_busy) n_busy++;
      if (obs_stall) n_stall++;
      else break;
    end
    quiet();
  endtask

  int ns, nb;
  int r;

  initial begin
    reset = 1'b1;
    quiet();
    @(posedge clk);
    @(posedge clk);
    #1;
    pipe = {bubble(), bubble(), bubble()};
    cyc = 0; md_v = 0;
    reset = 1'b0;

    // reset state
    cycle();
    cycle();

    // load-use: lw $1 then addu using $1
    set_d(0, 0, 3, 3, 1, 1, 2, 0, 0, 0); cycle();
    set_d(1, 0, 1, 3, 1, 6, 1, 0, 0, 0); cycle();
    chk("loaduse_stall", {3'b0, obs_stall}, 4'd1);
    cycle(); quiet(); cycle(); cycle(); cycle();

    // ALU back-to-back, then branch dependency
    set_d(0, 0, 3, 3, 1, 2, 1, 0, 0, 0); cycle();
    set_d(2, 0, 1, 3, 1, 7, 1, 0, 0, 0); cycle();
    chk("alu_nostall", {3'b0, obs_stall}, 4'd0);
    set_d(0, 0, 3, 3, 1, 3, 1, 0, 0, 0); cycle();
    set_d(3, 0, 0, 3, 0, 0, 0, 0, 0, 0); cycle();
    chk("branch_stall", {3'b0, obs_stall}, 4'd1);
    cycle(); quiet(); cycle(); cycle(); cycle();

    // jal in E, beq reading $31; write to $0 with Rs_D=0
    set_d(0, 0, 3, 3, 1, 31, 0, 0, 0, 0); cycle();
    set_d(31, 0, 0, 3, 0, 0, 0, 0, 0, 0); cycle();
    set_d(0, 0, 3, 3, 1, 0, 2, 0, 0, 0); cycle();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    quiet(); cycle(); cycle(); cycle();

    // store data forwarded from W
    set_d(0, 0, 3, 3, 1, 5, 1, 0, 0, 0); cycle();
    set_d(8, 5, 1, 2, 0, 0, 0, 0, 0, 0); cycle();
    quiet(); cycle(); cycle();
    chk("sw_fwd_wd", {3'b0, obs_wd}, 4'd1);
    cycle();

    // div / mult busy windows
    md_run(1'b1, ns, nb);
    chk("div_stall_len", 4'(ns), 4'd11);
    chk("div_busy_len", 4'(nb), 4'd10);
    cycle();
    md_run(1'b0, ns, nb);
    chk("mult_stall_len", 4'(ns), 4'd6);
    chk("mult_busy_len", 4'(nb), 4'd5);
    cycle();

    // reset in the middle of a div (counter at 7)
    set_d(1, 2, 1, 1, 0, 0, 1, 1, 1, 1); cycle();
    quiet(); cycle(); cycle(); cycle(); cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    cycle();
    chk("reset_busy_clear", {3'b0, obs_busy}, 4'd0);
    chk("reset_stall_clear", {3'b0, obs_stall}, 4'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      reset = (r < 1);
      if ($urandom_range(0, 9) == 0) begin
        set_d(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1, 1, 0, 0, 1,
              1, $urandom_range(0, 1) == 1, 1);
      end else begin
        set_d(int'($urandom_range(0, 4)) == 4 ? 31 : int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 4)) == 4 ? 31 : int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), 0, 0,
              $urandom_range(0, 7) == 0);
      end
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage MIPS pipeline.
- Keeps its own shadow pipeline of destination and timing info for the E, M and W stages.
- Generates stall and flush signals for the F/D registers and the D/E register, and forwarding selects for the D-stage and E-stage operand muxes.
- Tracks the busy window of the multi-cycle mult/div unit and stalls dependent instructions in D.

Parameters:
MULT_CYC, 5, busy cycles after a mult issues into E
DIV_CYC, 10, busy cycles after a div issues into E
CNT_W, 4, busy counter width; must hold DIV_CYC

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
Rs_D  in  5  D-stage rs field
Rt_D  in  5  D-stage rt field
Tuse_rs_D  in  2  cycles until rs is needed; 3 = unused
Tuse_rt_D  in  2  cycles until rt is needed; 3 = unused
RegWrite_D  in  1  D-stage instruction writes GRF
WriteReg_D  in  5  D-stage destination register
Tnew_D  in  2  cycles after entering E until result is ready (lui/jal 0, ALU 1, load 2)
md_start_D  in  1  D-stage instruction is mult/div
md_div_D  in  1  1 = div, 0 = mult (valid with md_start_D)
md_use_D  in  1  D-stage instruction reads or writes HI/LO or starts the MDU
Stall_F  out  1  hold PC
Stall_D  out  1  hold F/D register
CLR_E  out  1  flush D/E register (drives its CLR input)
ForwardA_D  out  2  rs source in D: 0 GRF, 1 M result, 2 E result
ForwardB_D  out  2  rt source in D, same encoding
ForwardA_E  out  2  rs source in E: 0 D/E register, 1 W result, 2 M result
ForwardB_E  out  2  rt source in E, same encoding
ForwardWD_M  out  1  M-stage store data: 1 = W result
md_busy  out  1  MDU counter is nonzero

Behaviour:
- Shadow registers:
  - E stage: wr_E, a_E, tn_E, rs_E, rt_E, st_E, dv_E.
  - M stage: wr_M, a_M, tn_M, rt_M.
  - W stage: wr_W, a_W.
  - Busy counter: cnt.
- Reset: all shadow registers and cnt go to 0 on the next clk edge. With D inputs quiet, every output is 0. Reset during an MDU operation clears cnt immediately and aborts the busy window.
- Each clk edge when not in reset:
  - If stall: E shadow is loaded with a bubble (all fields 0). This mirrors the D/E flush.
  - Otherwise: E shadow takes wr_E<=RegWrite_D, a_E<=WriteReg_D, tn_E<=Tnew_D, rs_E<=Rs_D, rt_E<=Rt_D, st_E<=md_start_D, dv_E<=md_div_D.
  - M shadow takes the E shadow, with tn_M = tn_E-1, saturating at 0.
  - W shadow takes the M shadow.
- Register $0: a match against register 0 never produces a stall or a forward.
- Stall (combinational, one per source):
  - rs stall = Tuse_rs_D!=3 and Rs_D!=0 and ((wr_E and a_E==Rs_D and tn_E>Tuse_rs_D) or (wr_M and a_M==Rs_D and tn_M>Tuse_rs_D)).
  - rt stall: same rule using Rt_D and Tuse_rt_D.
  - MDU stall = md_use_D and (st_E or cnt!=0).
  - stall = rs stall OR rt stall OR MDU stall.
  - Stall_F = Stall_D = CLR_E = stall.
- MDU counter:
  - If st_E: cnt <= dv_E ? DIV_CYC : MULT_CYC.
  - Else if cnt!=0: cnt <= cnt-1.
  - md_busy = (cnt!=0).
  - A mult/div issued into E with st_E=1 loads the counter on that edge. A following md_use instruction stalls for 1+LAT cycles in total.
- D-stage forwarding (ForwardA_D; ForwardB_D uses Rt_D):
  - 2 if wr_E, a_E==Rs_D, a_E!=0 and tn_E==0.
  - Else 1 if wr_M, a_M==Rs_D, a_M!=0 and tn_M==0.
  - Else 0.
  - E has priority over M.
  - W-to-D forwarding is handled inside the GRF.
- E-stage forwarding (ForwardA_E; ForwardB_E uses rt_E):
  - 2 if wr_M, a_M==rs_E, a_M!=0 and tn_M==0.
  - Else 1 if wr_W, a_W==rs_E and a_W!=0.
  - Else 0.
- ForwardWD_M = wr_W and a_W==rt_M and a_W!=0.
- A valid stalled pipeline never needs a forward from a stage whose result is not ready. The stall rule guarantees this.

Test Plan:
- Load-use: lw $1 (Tnew 2) in E while D holds addu using $1 with Tuse_rs 1 → stall=1 for 1 cycle; E shadow is a bubble; next cycle ForwardA_E=1 (from W) once the load reaches W.
- ALU back-to-back: addu $2 in E (Tnew 1), D uses $2 with Tuse 1 → no stall; next cycle ForwardA_E=2 (from M).
- Branch dependency: addu $3 in E, beq reading $3 in D (Tuse 0) → stall 1 cycle; next cycle ForwardA_D=1 (from M).
- jal/lui (Tnew 0) in E, beq in D reads $31 → ForwardA_D=2, no stall; writes to $0 with a matching Rs_D=0 → no stall and all forwards 0.
- div issued, then mfhi in D the next cycle → stall for 11 cycles (st_E, then cnt 10..1), md_busy high for 10 cycles; for mult the stall is 6 cycles.
- Reset asserted with cnt=7 → next edge cnt=0, md_busy=0, stall=0, all forward selects 0; sw in M with rt matching a W write → ForwardWD_M=1.
